snake_body_tracker: RTL and testbench

//   Owns snake motion state: head position, 20-segment body history, score and game FSM.

---
 rtl/snake_body_tracker.sv | 154 +++++++++++++++
 tb/tb_snake_body_tracker.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_tracker.sv
// Snake motion state: head position, body history, score and the IDLE/RUN/OVER game FSM.
// Body segments shift toward the tail on each move step; unused slots hold sentinel 10'h3FF.
module snake_body_tracker #(
  parameter int         TICK_CYCLES = 2500000,
  parameter logic [9:0] STEP        = 10'd20,
  parameter int         NSEG        = 20,
  parameter logic [9:0] START_X     = 10'd320,
  parameter logic [9:0] START_Y     = 10'd240
) (
  input  logic                vga_clk,
  input  logic                resetButton,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                eat,
  input  logic                endgame,
  output logic [9:0]          current_x,
  output logic [9:0]          current_y,
  output logic [10*NSEG-1:0]  stored_x,
  output logic [10*NSEG-1:0]  stored_y,
  output logic [7:0]          score_cnt,
  output logic                move_tick,
  output logic                running
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t                 state;
  logic [1:0]             dir;
  logic [1:0]             pend_dir;
  logic [TW-1:0]          tick_cnt;
  logic                   grow_pend;
  logic [NSEG-1:0][9:0]   seg_x;
  logic [NSEG-1:0][9:0]   seg_y;

  logic                   req_valid;
  logic [1:0]             req_dir;
  logic                   req_opposite;
  logic                   step;
  logic [7:0]             score_next;
  logic [8:0]             len;
  logic [9:0]             next_x;
  logic [9:0]             next_y;
  logic [NSEG-1:0][9:0]   shift_x;
  logic [NSEG-1:0][9:0]   shift_y;
  logic [NSEG-1:0][9:0]   seg_x_next;
  logic [NSEG-1:0][9:0]   seg_y_next;

  always_comb begin
    req_valid = btn_up | btn_down | btn_left | btn_right;
    req_dir   = DIR_RIGHT;
    if (btn_up)        req_dir = DIR_UP;
    else if (btn_down) req_dir = DIR_DOWN;
    else if (btn_left) req_dir = DIR_LEFT;
  end

  // Opposite directions differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
  assign req_opposite = ((req_dir ^ dir) == 2'b01);

  assign step = (state == RUN) && move_tick && !endgame;

  always_comb begin
    score_next = score_cnt;
    if ((grow_pend | eat) && (score_cnt != 8'hFF))
      score_next = score_cnt + 8'd1;
  end

  assign len = {1'b0, score_next} + 9'd2;

  always_comb begin
    next_x = current_x;
    next_y = current_y;
    case (pend_dir)
      DIR_UP:   next_y = current_y - STEP;
      DIR_DOWN: next_y = current_y + STEP;
      DIR_LEFT: next_x = current_x - STEP;
      default:  next_x = current_x + STEP;
    endcase
  end

  assign shift_x = {seg_x[NSEG-2:0], current_x};
  assign shift_y = {seg_y[NSEG-2:0], current_y};

  genvar gi;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_seg
      assign seg_x_next[gi] = (len > 9'(gi)) ? shift_x[gi] : 10'h3FF;
      assign seg_y_next[gi] = (len > 9'(gi)) ? shift_y[gi] : 10'h3FF;
    end
  endgenerate

  assign stored_x = seg_x;
  assign stored_y = seg_y;

  always_ff @(posedge vga_clk or negedge resetButton) begin
    if (!resetButton) begin
      state     <= IDLE;
      dir       <= DIR_RIGHT;
      pend_dir  <= DIR_RIGHT;
      tick_cnt  <= '0;
      move_tick <= 1'b0;
      current_x <= START_X;
      current_y <= START_Y;
      seg_x     <= '1;
      seg_y     <= '1;
      score_cnt <= 8'd0;
      grow_pend <= 1'b0;
      running   <= 1'b0;
    end else begin
      tick_cnt  <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
      move_tick <= (tick_cnt == TICK_LAST);

      // Checked against the committed direction so a quick double-tap cannot reverse.
      if (state != OVER && req_valid && !req_opposite)
        pend_dir <= req_dir;

      case (state)
        IDLE: begin
          if (req_valid) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (endgame) begin
            state   <= OVER;
            running <= 1'b0;
          end else if (step) begin
            dir       <= pend_dir;
            current_x <= next_x;
            current_y <= next_y;
            seg_x     <= seg_x_next;
            seg_y     <= seg_y_next;
            score_cnt <= score_next;
            grow_pend <= 1'b0;
          end else if (eat) begin
            grow_pend <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_tracker.sv
// Bench for snake_body_tracker with a 4-cycle move tick: vector table plus scoreboard of
// expected head/score/body per move step, and hand sequences for OVER, saturation and reset.
module tb_snake_body_tracker;

  logic               vga_clk = 1'b0;
  logic               resetButton = 1'b0;
  logic               btn_up = 1'b0;
  logic               btn_down = 1'b0;
  logic               btn_left = 1'b0;
  logic               btn_right = 1'b0;
  logic               eat = 1'b0;
  logic               endgame = 1'b0;
  logic [9:0]         current_x;
  logic [9:0]         current_y;
  logic [199:0]       stored_x;
  logic [199:0]       stored_y;
  logic [7:0]         score_cnt;
  logic               move_tick;
  logic               running;

  always #5 vga_clk = ~vga_clk;

  snake_body_tracker #(
    .TICK_CYCLES(4)
  ) dut (
    .vga_clk(vga_clk),
    .resetButton(resetButton),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .eat(eat),
    .endgame(endgame),
    .current_x(current_x),
    .current_y(current_y),
    .stored_x(stored_x),
    .stored_y(stored_y),
    .score_cnt(score_cnt),
    .move_tick(move_tick),
    .running(running)
  );

  typedef struct {
    int x;
    int y;
    int score;
    int s0x;
    int s0y;
    int nvalid;
  } exp_t;

  typedef struct {
    logic [3:0] btn_a;    // {up,down,left,right}, one cycle
    logic [3:0] btn_b;    // following cycle
    logic       eat_a;    // eat pulse with btn_a
    logic       eat_tick; // eat pulse coincident with the move tick
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int seg_x(input int k);
    return int'(stored_x[10*k +: 10]);
  endfunction

  function automatic int seg_y(input int k);
    return int'(stored_y[10*k +: 10]);
  endfunction

  function automatic int nvalid();
    int n = 0;
    for (int k = 0; k < 20; k++)
      if (stored_x[10*k +: 10] != 10'h3FF) n++;
    return n;
  endfunction

  function automatic vec_t mk(input logic [3:0] a, input logic [3:0] b, input logic ea,
                              input logic et, input int x, input int y, input int sc,
                              input int s0x, input int s0y, input int nv);
    vec_t v;
    v.btn_a = a; v.btn_b = b; v.eat_a = ea; v.eat_tick = et;
    v.e.x = x; v.e.y = y; v.e.score = sc; v.e.s0x = s0x; v.e.s0y = s0y; v.e.nvalid = nv;
    return v;
  endfunction

  task automatic set_btn(input logic [3:0] b);
    {btn_up, btn_down, btn_left, btn_right} = b;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (move_tick !== 1'b1 && n < 8) begin
      @(negedge vga_clk);
      n++;
    end
    chk("tick_seen", int'(move_tick === 1'b1), 1);
  endtask

  // Returns at the negedge just after the move-step edge.
  task automatic wait_step(input logic eat_tick);
    wait_tick();
    eat = eat_tick;
    @(negedge vga_clk);
    eat = 1'b0;
  endtask

  task automatic check_exp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_x"}, int'(current_x), e.x);
    chk({tag, "_y"}, int'(current_y), e.y);
    chk({tag, "_score"}, int'(score_cnt), e.score);
    chk({tag, "_seg0_x"}, seg_x(0), e.s0x);
    chk({tag, "_seg0_y"}, seg_y(0), e.s0y);
    chk({tag, "_nvalid"}, nvalid(), e.nvalid);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_running"}, int'(running), 0);
    chk({tag, "_x"}, int'(current_x), 320);
    chk({tag, "_y"}, int'(current_y), 240);
    chk({tag, "_score"}, int'(score_cnt), 0);
    chk({tag, "_tick"}, int'(move_tick), 0);
    chk({tag, "_stored_x"}, int'(stored_x == '1), 1);
    chk({tag, "_stored_y"}, int'(stored_y == '1), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(4'b0001, 4'b0000, 1'b0, 1'b0, 340, 240, 0, 320, 240, 1);
    vecs[1] = mk(4'b0000, 4'b0000, 1'b0, 1'b0, 360, 240, 0, 340, 240, 2);
    vecs[2] = mk(4'b0010, 4'b1000, 1'b0, 1'b0, 360, 220, 0, 360, 240, 2);
    vecs[3] = mk(4'b0000, 4'b0000, 1'b1, 1'b0, 360, 200, 1, 360, 220, 3);
    vecs[4] = mk(4'b0010, 4'b0000, 1'b0, 1'b0, 340, 200, 1, 360, 200, 3);
    vecs[5] = mk(4'b1100, 4'b0000, 1'b0, 1'b0, 340, 180, 1, 340, 200, 3);
    vecs[6] = mk(4'b0100, 4'b0011, 1'b0, 1'b0, 320, 180, 1, 340, 180, 3);
    vecs[7] = mk(4'b0000, 4'b0000, 1'b0, 1'b1, 300, 180, 2, 320, 180, 4);
    vecs[8] = mk(4'b0100, 4'b0000, 1'b0, 1'b0, 300, 200, 2, 300, 180, 4);
    vecs[9] = mk(4'b0001, 4'b0000, 1'b0, 1'b0, 320, 200, 2, 300, 200, 4);

    // Reset, then idle with no buttons; eat in IDLE must not count.
    repeat (3) @(negedge vga_clk);
    check_reset_outputs("rst");
    resetButton = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge vga_clk);
      chk("idle_tick", int'(move_tick), int'(k % 4 == 0));
      eat = (k == 9);
    end
    chk("idle_running", int'(running), 0);
    chk("idle_score", int'(score_cnt), 0);
    chk("idle_x", int'(current_x), 320);
    chk("idle_y", int'(current_y), 240);
    chk("idle_stored", int'(stored_x == '1 && stored_y == '1), 1);
    @(negedge vga_clk);

    for (int i = 0; i < 10; i++) begin
      sb.push_back(vecs[i].e);
      set_btn(vecs[i].btn_a);
      eat = vecs[i].eat_a;
      @(negedge vga_clk);
      set_btn(vecs[i].btn_b);
      eat = 1'b0;
      @(negedge vga_clk);
      set_btn(4'b0000);
      wait_step(vecs[i].eat_tick);
      check_exp($sformatf("vec%0d", i));
      $display("vec %0d head=(%0d,%0d) score=%0d running=%0d", i, current_x, current_y,
               score_cnt, running);
    end
    chk("run_running", int'(running), 1);

    // March right from x=320 to x=620.
    for (int i = 1; i <= 15; i++) begin
      exp_t e;
      e.x = 320 + 20 * i; e.y = 200; e.score = 2;
      e.s0x = 320 + 20 * (i - 1); e.s0y = 200; e.nvalid = 4;
      sb.push_back(e);
      wait_step(1'b0);
      check_exp($sformatf("march%0d", i));
    end
    $display("march head=(%0d,%0d)", current_x, current_y);

    // Endgame the cycle after the step: frozen through three more ticks despite inputs.
    endgame = 1'b1;
    @(negedge vga_clk);
    endgame = 1'b0;
    chk("over_running", int'(running), 0);
    set_btn(4'b1000);
    for (int t = 0; t < 3; t++) begin
      wait_step(1'b1);
      chk("over_x", int'(current_x), 620);
      chk("over_y", int'(current_y), 200);
      chk("over_score", int'(score_cnt), 2);
      chk("over_seg0_x", seg_x(0), 600);
      chk("over_nvalid", nvalid(), 4);
      chk("over_running", int'(running), 0);
      $display("over tick %0d head=(%0d,%0d)", t, current_x, current_y);
    end
    set_btn(4'b0000);

    // Fresh run, eat on every tick up to and past score saturation.
    @(negedge vga_clk);
    resetButton = 1'b0;
    @(negedge vga_clk);
    check_reset_outputs("rst2");
    set_btn(4'b0001);
    resetButton = 1'b1;
    @(negedge vga_clk);
    set_btn(4'b0000);
    for (int s = 1; s <= 256; s++) begin
      exp_t e;
      e.x = (320 + 20 * s) % 1024; e.y = 240;
      e.score = (s > 255) ? 255 : s;
      e.s0x = (320 + 20 * (s - 1)) % 1024; e.s0y = 240;
      e.nvalid = (s > 20) ? 20 : s;
      sb.push_back(e);
      wait_step(1'b1);
      check_exp($sformatf("grow%0d", s));
      if (s == 255) begin
        chk("sat_seg19_x", seg_x(19), (320 + 20 * 235) % 1024);
        chk("sat_seg19_y", seg_y(19), 240);
      end
      if (s % 64 == 0 || s == 255)
        $display("grow step %0d head=(%0d,%0d) score=%0d", s, current_x, current_y, score_cnt);
    end

    // Asynchronous reset between clock edges.
    @(negedge vga_clk);
    #2;
    resetButton = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    @(negedge vga_clk);

    // Endgame coincident with a move tick: no step on that edge.
    set_btn(4'b0001);
    resetButton = 1'b1;
    @(negedge vga_clk);
    set_btn(4'b0000);
    wait_tick();
    endgame = 1'b1;
    @(negedge vga_clk);
    endgame = 1'b0;
    chk("coinc_running", int'(running), 0);
    chk("coinc_x", int'(current_x), 320);
    chk("coinc_y", int'(current_y), 240);
    chk("coinc_nvalid", nvalid(), 0);
    $display("coincident endgame head=(%0d,%0d) running=%0d", current_x, current_y, running);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
